// File: rtl/input_stall_controller.sv
// Stalls the core during an IN instruction until the user confirms Switches with a held Button
// press (or a timeout forces capture), then presents one captured sample with a one-cycle strobe.
module input_stall_controller #(
  parameter int DATA_W      = 16,
  parameter int HOLD_CYCLES = 4,
  parameter int TIMEOUT     = 0,
  parameter int CNT_W       = 24
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              InReq,
  input  logic              Halt,
  input  logic              Button,
  input  logic [DATA_W-1:0] Switches,
  output logic              Stall,
  output logic              DataValid,
  output logic [DATA_W-1:0] DataOut,
  output logic              Waiting,
  output logic              TimedOut
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_RELEASE,
    S_WAIT_PRESS,
    S_HOLD,
    S_CAPTURE
  } state_t;

  localparam bit              TO_EN   = (TIMEOUT > 0);
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [CNT_W-1:0] HOLD_N  = CNT_W'(HOLD_CYCLES);

  state_t             state_q;
  logic [CNT_W-1:0]   hold_cnt_q;
  logic [CNT_W-1:0]   wait_cnt_q;
  logic [DATA_W-1:0]  data_q;
  logic               valid_q;
  logic               timed_out_q;

  logic               in_wait;
  logic               abort;
  logic               timeout_hit;
  logic [CNT_W-1:0]   hold_cnt_d;
  logic               hold_done;
  logic [CNT_W-1:0]   wait_cnt_d;

  assign in_wait     = (state_q == S_WAIT_RELEASE) || (state_q == S_WAIT_PRESS) ||
                       (state_q == S_HOLD);
  assign abort       = Halt || !InReq;
  assign timeout_hit = TO_EN && (wait_cnt_q == TO_LAST);
  assign hold_cnt_d  = hold_cnt_q + 1'b1;
  assign hold_done   = (hold_cnt_d == HOLD_N);
  // Saturate rather than wrap when the timeout is disabled and the user never answers.
  assign wait_cnt_d  = (&wait_cnt_q) ? wait_cnt_q : wait_cnt_q + 1'b1;

  // NOTE: sequential state uses non-blocking assignments only; combinational helpers above
  // are continuous assigns, so no process both reads and writes the same signal in one step.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q     <= S_IDLE;
      hold_cnt_q  <= '0;
      wait_cnt_q  <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      timed_out_q <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          hold_cnt_q <= '0;
          wait_cnt_q <= '0;
          if (InReq && !Halt) begin
            timed_out_q <= 1'b0;
            // A press still held from a previous IN must be released before it counts.
            state_q     <= Button ? S_WAIT_RELEASE : S_WAIT_PRESS;
          end
        end

        S_WAIT_RELEASE, S_WAIT_PRESS, S_HOLD: begin
          if (abort) begin
            state_q    <= S_IDLE;
            hold_cnt_q <= '0;
          end else if (timeout_hit) begin
            state_q     <= S_CAPTURE;
            data_q      <= Switches;
            valid_q     <= 1'b1;
            timed_out_q <= 1'b1;
          end else begin
            wait_cnt_q <= wait_cnt_d;
            if (state_q == S_WAIT_RELEASE) begin
              if (!Button) state_q <= S_WAIT_PRESS;
            end else if (Button) begin
              if (hold_done) begin
                state_q <= S_CAPTURE;
                data_q  <= Switches;
                valid_q <= 1'b1;
              end else begin
                state_q    <= S_HOLD;
                hold_cnt_q <= hold_cnt_d;
              end
            end else begin
              // Press released before the hold count: treat it as a glitch and start over.
              state_q    <= S_WAIT_PRESS;
              hold_cnt_q <= '0;
            end
          end
        end

        S_CAPTURE: state_q <= S_IDLE;

        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Stall must cover the first IN cycle before the FSM leaves IDLE, hence the InReq term.
  assign Stall     = !Reset && (in_wait || ((state_q == S_IDLE) && InReq && !Halt));
  assign Waiting   = in_wait;
  assign DataValid = valid_q;
  assign DataOut   = data_q;
  assign TimedOut  = timed_out_q;

endmodule

// File: tb/tb_input_stall_controller.sv
// Randomized bench for input_stall_controller: a behavioural model of the IN handshake predicts
// per-cycle outputs and queues expected samples; a monitor pops them whenever DataValid fires.
module tb_input_stall_controller;

  localparam int DATA_W = 16;
  localparam int HOLD   = 4;
  localparam int TOUT   = 100;

  logic              Clock = 1'b0;
  logic              Reset;
  logic              InReq, Halt, Button;
  logic [DATA_W-1:0] Switches;
  logic              Stall, DataValid, Waiting, TimedOut;
  logic [DATA_W-1:0] DataOut;

  input_stall_controller #(
    .DATA_W(DATA_W), .HOLD_CYCLES(HOLD), .TIMEOUT(TOUT), .CNT_W(24)
  ) dut (
    .Clock(Clock), .Reset(Reset), .InReq(InReq), .Halt(Halt), .Button(Button),
    .Switches(Switches), .Stall(Stall), .DataValid(DataValid), .DataOut(DataOut),
    .Waiting(Waiting), .TimedOut(TimedOut)
  );

  always #5 Clock = ~Clock;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // Reference model: "busy" = an IN is waiting on the user, "armed" = a release has been seen
  // since the IN began, run = consecutive high samples, elapsed = wait cycles spent so far.
  bit                m_busy, m_armed, m_cap, m_to;
  int                m_run, m_elapsed;
  logic [DATA_W-1:0] m_dout;
  logic [DATA_W-1:0] exp_q[$];

  task automatic model_reset();
    m_busy = 0; m_armed = 0; m_cap = 0; m_to = 0;
    m_run = 0; m_elapsed = 0; m_dout = '0;
    exp_q.delete();
  endtask

  task automatic take(input bit forced);
    m_busy = 0;
    m_cap  = 1;
    m_dout = Switches;
    if (forced) m_to = 1;
    exp_q.push_back(Switches);
  endtask

  // Advance the model by one clock edge using the inputs the DUT just sampled.
  task automatic model_edge();
    if (m_cap) begin
      m_cap = 0;
    end else if (!m_busy) begin
      if (InReq && !Halt) begin
        m_busy = 1; m_armed = !Button; m_run = 0; m_elapsed = 0; m_to = 0;
      end
    end else if (Halt || !InReq) begin
      m_busy = 0;
    end else begin
      m_elapsed++;
      if (m_elapsed == TOUT) take(1);
      else if (!m_armed) m_armed = !Button;
      else if (Button) begin
        m_run++;
        if (m_run == HOLD) take(0);
      end else m_run = 0;
    end
  endtask

  task automatic check_outputs();
    check("stall",     Stall,     m_busy || (!m_cap && !m_busy && InReq && !Halt));
    check("waiting",   Waiting,   m_busy);
    check("datavalid", DataValid, m_cap);
    check("timedout",  TimedOut,  m_to);
    check("dataout",   DataOut,   m_dout);
  endtask

  task automatic step(input logic r, input logic h, input logic b, input logic [DATA_W-1:0] s);
    @(posedge Clock); #1;
    model_edge();
    InReq = r; Halt = h; Button = b; Switches = s;
    @(negedge Clock);
    check_outputs();
  endtask

  task automatic run(input int n, input logic r, input logic h, input logic b,
                     input logic [DATA_W-1:0] s);
    for (int i = 0; i < n; i++) step(r, h, b, s);
  endtask

  task automatic pulse_reset();
    @(posedge Clock); #1;
    model_edge();
    Reset = 1'b1;
    #1;
    check("rst_stall",     Stall,     1'b0);
    check("rst_datavalid", DataValid, 1'b0);
    check("rst_dataout",   DataOut,   '0);
    check("rst_waiting",   Waiting,   1'b0);
    check("rst_timedout",  TimedOut,  1'b0);
    model_reset();
    @(negedge Clock);
    Reset = 1'b0;
  endtask

  // Monitor: every DataValid strobe must match the oldest predicted sample.
  always @(negedge Clock) begin
    if (!Reset && DataValid) begin
      if (exp_q.size() == 0) check("dv_unexpected", DataValid, 1'b0);
      else check("sample", DataOut, exp_q.pop_front());
    end
  end

  initial begin
    logic              rb, rr, rh;
    int                b_left, r_left;
    logic [DATA_W-1:0] rs;

    Reset = 1'b1; InReq = 1'b1; Halt = 1'b0; Button = 1'b0; Switches = 16'hFFFF;
    model_reset();
    #3;
    check("init_stall",    Stall,     1'b0);
    check("init_dataout",  DataOut,   '0);
    check("init_waiting",  Waiting,   1'b0);
    check("init_timedout", TimedOut,  1'b0);
    InReq = 1'b0;
    repeat (2) @(negedge Clock);
    Reset = 1'b0;

    // Basic capture of 16'h00A5 after a 4-edge press.
    run(2, 0, 0, 0, 16'h0000);
    run(3, 1, 0, 0, 16'h00A5);
    run(4, 1, 0, 1, 16'h00A5);
    run(3, 0, 0, 0, 16'h00A5);
    // Short press is rejected, second full press captures.
    run(2, 1, 0, 0, 16'h0B0B);
    run(2, 1, 0, 1, 16'h0B0B);
    run(2, 1, 0, 0, 16'h0C0C);
    run(4, 1, 0, 1, 16'h0C0C);
    run(2, 0, 0, 0, 16'h0C0C);
    // Button already held when IN arrives, then back-to-back IN with button still held.
    run(1, 0, 0, 1, 16'h7777);
    run(6, 1, 0, 1, 16'h7777);
    run(2, 1, 0, 0, 16'h5555);
    run(4, 1, 0, 1, 16'h5555);
    run(6, 1, 0, 1, 16'h1234);
    run(1, 1, 0, 0, 16'h1234);
    run(4, 1, 0, 1, 16'h1234);
    run(2, 0, 0, 0, 16'h1234);
    // No press: timeout forces capture; the next IN clears TimedOut.
    run(TOUT + 5, 1, 0, 0, 16'hBEEF);
    run(3, 0, 0, 0, 16'hBEEF);
    run(2, 1, 0, 0, 16'h0F0F);
    run(4, 1, 0, 1, 16'h0F0F);
    run(2, 0, 0, 0, 16'h0F0F);
    // Halt during HOLD, then Reset during WAIT_PRESS.
    run(2, 1, 0, 0, 16'h2222);
    run(2, 1, 0, 1, 16'h2222);
    run(1, 1, 1, 1, 16'h2222);
    run(3, 0, 0, 0, 16'h2222);
    run(3, 1, 0, 0, 16'h3333);
    pulse_reset();
    run(3, 0, 0, 0, 16'h3333);

    // Randomized traffic: button bursts, occasional long silences, InReq drops, Halts, resets.
    rb = 0; rr = 1; b_left = 3; r_left = 50;
    for (int c = 0; c < 4000; c++) begin
      if (b_left == 0) begin
        rb = !rb;
        if (rb) b_left = $urandom_range(1, 6);
        else b_left = ($urandom_range(0, 9) == 0) ? $urandom_range(90, 130) : $urandom_range(1, 5);
      end
      b_left--;
      if (r_left == 0) begin
        rr = !rr;
        r_left = rr ? $urandom_range(5, 200) : $urandom_range(1, 4);
      end
      r_left--;
      rh = ($urandom_range(0, 59) == 0);
      rs = DATA_W'($urandom);
      if ($urandom_range(0, 499) == 0) pulse_reset();
      else step(rr, rh, rb, rs);
    end

    run(4, 0, 0, 0, 16'h0000);
    check("queue_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
